// File: rtl/etx_arbiter.sv
// etx_arbiter: selects one of three transmit channels (rr/wr/rq) and
// holds the chosen transaction until the protocol stage acknowledges it.
module etx_arbiter #(
   parameter int RR_EN = 1
) (
   input  logic         tx_lclk_par,
   input  logic         nreset,
   input  logic         emwr_access,
   input  logic         emrq_access,
   input  logic         emrr_access,
   input  logic [102:0] emwr_packet,
   input  logic [102:0] emrq_packet,
   input  logic [102:0] emrr_packet,
   output logic         emwr_rd_en,
   output logic         emrq_rd_en,
   output logic         emrr_rd_en,
   output logic         etx_access,
   output logic         etx_write,
   output logic [1:0]   etx_datamode,
   output logic [3:0]   etx_ctrlmode,
   output logic [31:0]  etx_dstaddr,
   output logic [31:0]  etx_srcaddr,
   output logic [31:0]  etx_data,
   input  logic         etx_ack,
   input  logic         etx_rd_wait,
   input  logic         etx_wr_wait
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [1:0] CH_RR = 2'd0;
   localparam logic [1:0] CH_WR = 2'd1;
   localparam logic [1:0] CH_RQ = 2'd2;

   state_t         state_q;
   logic [1:0]     ptr_q;
   logic           access_q;
   logic [102:0]   pkt_q;

   logic [2:0]     elig;
   logic [2:0]     gnt;
   logic [1:0]     gnt_idx;
   logic [1:0]     first;
   logic           load;
   logic [102:0]   pkt_sel;

   // Channel eligibility; bit 0 = rr, bit 1 = wr, bit 2 = rq.
   always_comb begin
      elig[0] = emrr_access & ~etx_wr_wait;
      elig[1] = emwr_access & ~etx_wr_wait;
      elig[2] = emrq_access & ~etx_rd_wait;
   end

   // A new packet may be taken when idle or when the held one is acked.
   always_comb begin
      load = nreset & ((state_q == IDLE) | etx_ack);
   end

   // Grant search: round-robin starts after the last grant, else fixed.
   always_comb begin
      gnt = 3'b000;
      if (RR_EN != 0) begin
         first = (ptr_q == CH_RQ) ? CH_RR : ptr_q + 2'd1;
      end else begin
         first = CH_RR;
      end
      case (first)
         CH_WR: begin
            if (elig[1])      gnt = 3'b010;
            else if (elig[2]) gnt = 3'b100;
            else if (elig[0]) gnt = 3'b001;
         end
         CH_RQ: begin
            if (elig[2])      gnt = 3'b100;
            else if (elig[0]) gnt = 3'b001;
            else if (elig[1]) gnt = 3'b010;
         end
         default: begin
            if (elig[0])      gnt = 3'b001;
            else if (elig[1]) gnt = 3'b010;
            else if (elig[2]) gnt = 3'b100;
         end
      endcase
   end

   // Winning channel index and its packet.
   always_comb begin
      gnt_idx = CH_RR;
      if (gnt[1]) gnt_idx = CH_WR;
      if (gnt[2]) gnt_idx = CH_RQ;
      pkt_sel = ({103{gnt[0]}} & emrr_packet)
              | ({103{gnt[1]}} & emwr_packet)
              | ({103{gnt[2]}} & emrq_packet);
   end

   // FIFO pops only on an actual load; gated off while in reset.
   always_comb begin
      emrr_rd_en = load & gnt[0];
      emwr_rd_en = load & gnt[1];
      emrq_rd_en = load & gnt[2];
   end

   // Hold/idle state machine with registered transaction fields.
   always_ff @(posedge tx_lclk_par) begin
      if (!nreset) begin
         state_q  <= IDLE;
         access_q <= 1'b0;
         pkt_q    <= '0;
         ptr_q    <= CH_RQ;
      end else if (load) begin
         if (|gnt) begin
            state_q  <= HOLD;
            access_q <= 1'b1;
            pkt_q    <= pkt_sel;
            ptr_q    <= gnt_idx;
         end else begin
            state_q  <= IDLE;
            access_q <= 1'b0;
         end
      end
   end

   assign etx_access   = access_q;
   assign etx_write    = pkt_q[102];
   assign etx_datamode = pkt_q[101:100];
   assign etx_ctrlmode = pkt_q[99:96];
   assign etx_dstaddr  = pkt_q[95:64];
   assign etx_srcaddr  = pkt_q[63:32];
   assign etx_data     = pkt_q[31:0];

endmodule

// File: tb/tb_etx_arbiter.sv
// tb_etx_arbiter: table-driven check of round-robin and fixed-priority
// arbiter instances sharing one stimulus stream.
module tb_etx_arbiter;

   logic         clk;
   logic         nreset;
   logic         emwr_access, emrq_access, emrr_access;
   logic [102:0] emwr_packet, emrq_packet, emrr_packet;
   logic         etx_ack, etx_rd_wait, etx_wr_wait;

   logic         r_wr_rd, r_rq_rd, r_rr_rd, r_acc, r_write;
   logic [1:0]   r_dm;
   logic [3:0]   r_cm;
   logic [31:0]  r_dst, r_src, r_data;

   logic         f_wr_rd, f_rq_rd, f_rr_rd, f_acc, f_write;
   logic [1:0]   f_dm;
   logic [3:0]   f_cm;
   logic [31:0]  f_dst, f_src, f_data;

   int n_chk  = 0;
   int n_fail = 0;

   etx_arbiter #(.RR_EN(1)) u_rr (
      .tx_lclk_par (clk),
      .nreset      (nreset),
      .emwr_access (emwr_access),
      .emrq_access (emrq_access),
      .emrr_access (emrr_access),
      .emwr_packet (emwr_packet),
      .emrq_packet (emrq_packet),
      .emrr_packet (emrr_packet),
      .emwr_rd_en  (r_wr_rd),
      .emrq_rd_en  (r_rq_rd),
      .emrr_rd_en  (r_rr_rd),
      .etx_access  (r_acc),
      .etx_write   (r_write),
      .etx_datamode(r_dm),
      .etx_ctrlmode(r_cm),
      .etx_dstaddr (r_dst),
      .etx_srcaddr (r_src),
      .etx_data    (r_data),
      .etx_ack     (etx_ack),
      .etx_rd_wait (etx_rd_wait),
      .etx_wr_wait (etx_wr_wait)
   );

   etx_arbiter #(.RR_EN(0)) u_fp (
      .tx_lclk_par (clk),
      .nreset      (nreset),
      .emwr_access (emwr_access),
      .emrq_access (emrq_access),
      .emrr_access (emrr_access),
      .emwr_packet (emwr_packet),
      .emrq_packet (emrq_packet),
      .emrr_packet (emrr_packet),
      .emwr_rd_en  (f_wr_rd),
      .emrq_rd_en  (f_rq_rd),
      .emrr_rd_en  (f_rr_rd),
      .etx_access  (f_acc),
      .etx_write   (f_write),
      .etx_datamode(f_dm),
      .etx_ctrlmode(f_cm),
      .etx_dstaddr (f_dst),
      .etx_srcaddr (f_src),
      .etx_data    (f_data),
      .etx_ack     (etx_ack),
      .etx_rd_wait (etx_rd_wait),
      .etx_wr_wait (etx_wr_wait)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [31:0] D_RR = 32'hAAAA_0001;
   localparam logic [31:0] D_WR = 32'hDEAD_BEEF;
   localparam logic [31:0] D_RQ = 32'hCCCC_0003;

   typedef struct {
      logic        rst;
      logic [2:0]  acc;
      logic        wrw;
      logic        rdw;
      logic        ack;
      logic [2:0]  rd_r;
      logic        a_r;
      logic [31:0] d_r;
      logic [2:0]  rd_f;
      logic        a_f;
      logic [31:0] d_f;
   } vec_t;

   function automatic logic [31:0] dv(input int id);
      case (id)
         1:       return D_RR;
         2:       return D_WR;
         3:       return D_RQ;
         default: return 32'h0;
      endcase
   endfunction

   function automatic vec_t mk(
      input logic rst, input logic [2:0] acc,
      input logic wrw, input logic rdw, input logic ack,
      input logic [2:0] rd_r, input logic a_r, input int d_r,
      input logic [2:0] rd_f, input logic a_f, input int d_f);
      vec_t v;
      v.rst  = rst;  v.acc = acc;  v.wrw = wrw;
      v.rdw  = rdw;  v.ack = ack;
      v.rd_r = rd_r; v.a_r = a_r;  v.d_r = dv(d_r);
      v.rd_f = rd_f; v.a_f = a_f;  v.d_f = dv(d_f);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   vec_t tv [31];

   initial begin
      nreset      = 1'b0;
      emrr_access = 1'b0;
      emwr_access = 1'b0;
      emrq_access = 1'b0;
      etx_ack     = 1'b0;
      etx_wr_wait = 1'b0;
      etx_rd_wait = 1'b0;
      emrr_packet = {1'b0, 2'd2, 4'd3, 32'h1111_0000, 32'h1111_1111, D_RR};
      emwr_packet = {1'b1, 2'd2, 4'd0, 32'h8080_0000, 32'h0, D_WR};
      emrq_packet = {1'b0, 2'd1, 4'd5, 32'h3333_0000, 32'h4444_0000, D_RQ};

      // acc bits: [0]=rr [1]=wr [2]=rq; rd_en in the same order
      tv[0]  = mk(0, 3'b111, 0, 0, 0, 3'b000, 0, 0, 3'b000, 0, 0);
      tv[1]  = mk(0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 3'b000, 0, 0);
      tv[2]  = mk(1, 3'b010, 0, 0, 0, 3'b010, 1, 2, 3'b010, 1, 2);
      tv[3]  = mk(1, 3'b010, 0, 0, 0, 3'b000, 1, 2, 3'b000, 1, 2);
      tv[4]  = mk(1, 3'b010, 1, 0, 0, 3'b000, 1, 2, 3'b000, 1, 2);
      tv[5]  = mk(1, 3'b010, 1, 0, 1, 3'b000, 0, 0, 3'b000, 0, 0);
      tv[6]  = mk(1, 3'b000, 0, 0, 1, 3'b000, 0, 0, 3'b000, 0, 0);
      tv[7]  = mk(1, 3'b111, 0, 0, 0, 3'b100, 1, 3, 3'b001, 1, 1);
      tv[8]  = mk(1, 3'b111, 0, 0, 0, 3'b000, 1, 3, 3'b000, 1, 1);
      tv[9]  = mk(1, 3'b111, 0, 0, 1, 3'b001, 1, 1, 3'b001, 1, 1);
      tv[10] = mk(1, 3'b111, 0, 0, 0, 3'b000, 1, 1, 3'b000, 1, 1);
      tv[11] = mk(1, 3'b111, 0, 0, 1, 3'b010, 1, 2, 3'b001, 1, 1);
      tv[12] = mk(1, 3'b111, 0, 0, 0, 3'b000, 1, 2, 3'b000, 1, 1);
      tv[13] = mk(1, 3'b111, 0, 0, 1, 3'b100, 1, 3, 3'b001, 1, 1);
      tv[14] = mk(1, 3'b111, 0, 0, 0, 3'b000, 1, 3, 3'b000, 1, 1);
      tv[15] = mk(1, 3'b111, 0, 0, 1, 3'b001, 1, 1, 3'b001, 1, 1);
      tv[16] = mk(1, 3'b111, 0, 0, 0, 3'b000, 1, 1, 3'b000, 1, 1);
      tv[17] = mk(1, 3'b111, 0, 0, 1, 3'b010, 1, 2, 3'b001, 1, 1);
      tv[18] = mk(1, 3'b111, 0, 0, 0, 3'b000, 1, 2, 3'b000, 1, 1);
      tv[19] = mk(1, 3'b111, 0, 0, 1, 3'b100, 1, 3, 3'b001, 1, 1);
      tv[20] = mk(1, 3'b110, 1, 0, 1, 3'b100, 1, 3, 3'b100, 1, 3);
      tv[21] = mk(1, 3'b110, 1, 0, 0, 3'b000, 1, 3, 3'b000, 1, 3);
      tv[22] = mk(1, 3'b110, 1, 0, 1, 3'b100, 1, 3, 3'b100, 1, 3);
      tv[23] = mk(1, 3'b110, 0, 0, 1, 3'b010, 1, 2, 3'b010, 1, 2);
      tv[24] = mk(1, 3'b110, 0, 0, 0, 3'b000, 1, 2, 3'b000, 1, 2);
      tv[25] = mk(0, 3'b111, 0, 0, 0, 3'b000, 0, 0, 3'b000, 0, 0);
      tv[26] = mk(1, 3'b111, 0, 0, 0, 3'b001, 1, 1, 3'b001, 1, 1);
      tv[27] = mk(1, 3'b111, 0, 1, 1, 3'b010, 1, 2, 3'b001, 1, 1);
      tv[28] = mk(1, 3'b100, 0, 1, 1, 3'b000, 0, 0, 3'b000, 0, 0);
      tv[29] = mk(1, 3'b100, 0, 0, 0, 3'b100, 1, 3, 3'b100, 1, 3);
      tv[30] = mk(1, 3'b000, 0, 0, 1, 3'b000, 0, 0, 3'b000, 0, 0);

      for (int i = 0; i < 31; i++) begin
         @(negedge clk);
         nreset      = tv[i].rst;
         emrr_access = tv[i].acc[0];
         emwr_access = tv[i].acc[1];
         emrq_access = tv[i].acc[2];
         etx_wr_wait = tv[i].wrw;
         etx_rd_wait = tv[i].rdw;
         etx_ack     = tv[i].ack;
         #1;
         chk($sformatf("v%0d rr_rd_en", i),
             {29'b0, r_rq_rd, r_wr_rd, r_rr_rd}, {29'b0, tv[i].rd_r});
         chk($sformatf("v%0d fp_rd_en", i),
             {29'b0, f_rq_rd, f_wr_rd, f_rr_rd}, {29'b0, tv[i].rd_f});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d rr_access", i), {31'b0, r_acc},
             {31'b0, tv[i].a_r});
         chk($sformatf("v%0d fp_access", i), {31'b0, f_acc},
             {31'b0, tv[i].a_f});
         if (tv[i].a_r || !tv[i].rst)
            chk($sformatf("v%0d rr_data", i), r_data, tv[i].d_r);
         if (tv[i].a_f || !tv[i].rst)
            chk($sformatf("v%0d fp_data", i), f_data, tv[i].d_f);
      end

      // Single write: full field check, held stable until ack.
      @(negedge clk);
      emwr_access = 1'b1;
      etx_ack     = 1'b0;
      #1;
      chk("seq wr pop", {31'b0, r_wr_rd}, 32'd1);
      @(posedge clk);
      #1;
      chk("seq access", {31'b0, r_acc}, 32'd1);
      chk("seq write", {31'b0, r_write}, 32'd1);
      chk("seq datamode", {30'b0, r_dm}, 32'd2);
      chk("seq ctrlmode", {28'b0, r_cm}, 32'd0);
      chk("seq dstaddr", r_dst, 32'h8080_0000);
      chk("seq srcaddr", r_src, 32'h0);
      chk("seq data", r_data, D_WR);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         etx_wr_wait = k[0];
         #1;
         chk($sformatf("seq hold%0d pop", k), {31'b0, r_wr_rd}, 32'd0);
         @(posedge clk);
         #1;
         chk($sformatf("seq hold%0d data", k), r_data, D_WR);
         chk($sformatf("seq hold%0d acc", k), {31'b0, r_acc}, 32'd1);
      end
      @(negedge clk);
      emwr_access = 1'b0;
      etx_wr_wait = 1'b0;
      etx_ack     = 1'b1;
      #1;
      chk("seq ack pop", {31'b0, r_wr_rd}, 32'd0);
      @(posedge clk);
      #1;
      chk("seq ack idle", {31'b0, r_acc}, 32'd0);
      @(negedge clk);
      etx_ack = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
